// File: rtl/e_muldiv_ctrl.sv
// e_muldiv_ctrl: execute-stage multiply/divide sequencer.
// Owns HI/LO and runs a radix-2 shift-add multiplier and a restoring divider
// in the background. The E stage is paused only when it tries to touch HI/LO
// or issue another muldiv op while one is still in flight.
module e_muldiv_ctrl #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_con_valid,
  input  logic [2:0]   i_con_op,
  input  logic [W-1:0] i_data_A,
  input  logic [W-1:0] i_data_B,
  input  logic [1:0]   i_con_mf,
  output logic         o_con_pause,
  output logic         o_con_busy,
  output logic         o_con_divzero,
  output logic [W-1:0] o_data_Hi,
  output logic [W-1:0] o_data_Lo
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  typedef enum logic [1:0] {K_MUL, K_DIV, K_DZ} kind_t;

  state_t         state;
  kind_t          kind;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   mag_a;    // |A| for mul/div; raw A for divide-by-zero
  logic [W-1:0]   mag_b;    // |B| divisor
  logic [2*W-1:0] acc;      // product high half : remaining multiplier bits
  logic [W-1:0]   rem;
  logic [W-1:0]   quo;      // dividend bits shift out as quotient bits shift in
  logic           neg_p, neg_q, neg_r;

  logic           req_op, req_mf, op_signed, sign_a, sign_b;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     mul_sum, div_shift, div_diff;
  logic [2*W-1:0] prod_fix;

  // Request decode and operand magnitudes
  always_comb begin
    req_op    = i_con_valid && (i_con_op != 3'b000) && (i_con_op != 3'b111);
    req_mf    = i_con_valid && ((i_con_mf == 2'b01) || (i_con_mf == 2'b10));
    op_signed = (i_con_op == OP_MULT) || (i_con_op == OP_DIV);
    sign_a    = op_signed & i_data_A[W-1];
    sign_b    = op_signed & i_data_B[W-1];
    a_mag     = sign_a ? -i_data_A : i_data_A;
    b_mag     = sign_b ? -i_data_B : i_data_B;
  end

  // One shift-add / restoring step, plus the signed product fix-up
  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, mag_a & {W{acc[0]}}};
    div_shift = {rem, quo[W-1]};
    div_diff  = div_shift - {1'b0, mag_b};
    prod_fix  = neg_p ? -acc : acc;
  end

  assign o_con_busy  = (state != IDLE);
  assign o_con_pause = o_con_busy && (req_op || req_mf);

  // Sequencer FSM, datapath registers and HI/LO
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      kind          <= K_MUL;
      cnt           <= '0;
      mag_a         <= '0;
      mag_b         <= '0;
      acc           <= '0;
      rem           <= '0;
      quo           <= '0;
      neg_p         <= 1'b0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      o_con_divzero <= 1'b0;
      o_data_Hi     <= '0;
      o_data_Lo     <= '0;
    end else begin
      o_con_divzero <= 1'b0;
      case (state)
        IDLE: if (req_op) begin
          cnt <= '0;
          case (i_con_op)
            OP_MULT, OP_MULTU: begin
              mag_a <= a_mag;
              acc   <= {{W{1'b0}}, b_mag};
              neg_p <= sign_a ^ sign_b;
              kind  <= K_MUL;
              state <= MUL;
            end
            OP_DIV, OP_DIVU: begin
              if (i_data_B == '0) begin
                mag_a <= i_data_A;
                kind  <= K_DZ;
                state <= FIX;
              end else begin
                mag_b <= b_mag;
                rem   <= '0;
                quo   <= a_mag;
                neg_q <= sign_a ^ sign_b;
                neg_r <= sign_a;
                kind  <= K_DIV;
                state <= DIV;
              end
            end
            OP_MTHI: o_data_Hi <= i_data_A;
            OP_MTLO: o_data_Lo <= i_data_A;
            default: ;
          endcase
        end
        MUL: begin
          acc <= {mul_sum, acc[W-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W-1)) state <= FIX;
        end
        DIV: begin
          if (!div_diff[W]) begin
            rem <= div_diff[W-1:0];
            quo <= {quo[W-2:0], 1'b1};
          end else begin
            rem <= div_shift[W-1:0];
            quo <= {quo[W-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W-1)) state <= FIX;
        end
        FIX: begin
          case (kind)
            K_MUL: {o_data_Hi, o_data_Lo} <= prod_fix;
            K_DIV: begin
              o_data_Lo <= neg_q ? -quo : quo;
              o_data_Hi <= neg_r ? -rem : rem;
            end
            default: begin
              o_data_Hi     <= mag_a;
              o_data_Lo     <= '1;
              o_con_divzero <= 1'b1;
            end
          endcase
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_e_muldiv_ctrl.sv
// Directed bench for e_muldiv_ctrl: result values, busy/pause timing,
// divide-by-zero pulse, MT/MF interlock and asynchronous reset abort.
module tb_e_muldiv_ctrl;
  localparam int W = 32;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_con_valid;
  logic [2:0]   i_con_op;
  logic [W-1:0] i_data_A, i_data_B;
  logic [1:0]   i_con_mf;
  logic         o_con_pause, o_con_busy, o_con_divzero;
  logic [W-1:0] o_data_Hi, o_data_Lo;

  int checks = 0;
  int failures = 0;

  e_muldiv_ctrl #(.W(W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_con_valid(i_con_valid), .i_con_op(i_con_op),
    .i_data_A(i_data_A), .i_data_B(i_data_B), .i_con_mf(i_con_mf),
    .o_con_pause(o_con_pause), .o_con_busy(o_con_busy), .o_con_divzero(o_con_divzero),
    .o_data_Hi(o_data_Hi), .o_data_Lo(o_data_Lo)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  // Present one op for one cycle, then count busy cycles after acceptance.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_busy);
    int n;
    i_con_valid = 1'b1; i_con_op = op; i_data_A = a; i_data_B = b;
    #1;
    chk({tag, "_pause"}, {31'd0, o_con_pause}, 32'd0);
    step();
    i_con_valid = 1'b0; i_con_op = 3'b000;
    n = 0;
    while (o_con_busy && n < 100) begin
      n++;
      step();
    end
    chk({tag, "_busy"}, 32'(n), 32'(exp_busy));
  endtask

  initial begin
    int n;
    i_rst = 1'b1; i_con_valid = 1'b0; i_con_op = 3'b000;
    i_data_A = '0; i_data_B = '0; i_con_mf = 2'b00;
    #2;
    chk("rst_hi", o_data_Hi, 32'h0);
    chk("rst_lo", o_data_Lo, 32'h0);
    chk("rst_flags", {29'd0, o_con_pause, o_con_busy, o_con_divzero}, 32'd0);
    step(); step();
    i_rst = 1'b0;
    step();

    // Op code without valid must not start anything
    i_con_op = 3'b001; i_data_A = 32'd3; i_data_B = 32'd3;
    step();
    chk("novalid_busy", {31'd0, o_con_busy}, 32'd0);
    i_con_op = 3'b000;

    do_op("mult", 3'b001, 32'hFFFF_FFFD, 32'd5, 33);
    chk("mult_hi", o_data_Hi, 32'hFFFF_FFFF);
    chk("mult_lo", o_data_Lo, 32'hFFFF_FFF1);
    chk("mult_dz", {31'd0, o_con_divzero}, 32'd0);

    do_op("multu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    chk("multu_hi", o_data_Hi, 32'hFFFF_FFFE);
    chk("multu_lo", o_data_Lo, 32'h0000_0001);

    do_op("div", 3'b011, 32'hFFFF_FFF9, 32'd2, 33);
    chk("div_lo", o_data_Lo, 32'hFFFF_FFFD);
    chk("div_hi", o_data_Hi, 32'hFFFF_FFFF);

    do_op("divu", 3'b100, 32'd7, 32'd2, 33);
    chk("divu_lo", o_data_Lo, 32'd3);
    chk("divu_hi", o_data_Hi, 32'd1);

    // Divide by zero: result and pulse on edge 1, pulse gone one cycle later
    do_op("dz", 3'b100, 32'h0000_1234, 32'd0, 1);
    chk("dz_hi", o_data_Hi, 32'h0000_1234);
    chk("dz_lo", o_data_Lo, 32'hFFFF_FFFF);
    chk("dz_pulse", {31'd0, o_con_divzero}, 32'd1);
    step();
    chk("dz_pulse_end", {31'd0, o_con_divzero}, 32'd0);

    do_op("divovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 33);
    chk("divovf_lo", o_data_Lo, 32'h8000_0000);
    chk("divovf_hi", o_data_Hi, 32'h0);

    // MTHI while idle: immediate, LO untouched
    do_op("mthi", 3'b101, 32'hA5A5_A5A5, 32'd0, 0);
    chk("mthi_hi", o_data_Hi, 32'hA5A5_A5A5);
    chk("mthi_lo", o_data_Lo, 32'h8000_0000);

    // MULT accepted, one bubble, then MFLO waits out the remaining 32 busy cycles
    i_con_valid = 1'b1; i_con_op = 3'b001; i_data_A = 32'd3; i_data_B = 32'd4;
    step();
    i_con_valid = 1'b0; i_con_op = 3'b000;
    step();
    i_con_valid = 1'b1; i_con_mf = 2'b10;
    #1;
    n = 0;
    while (o_con_pause && n < 100) begin
      n++;
      step();
    end
    chk("mflo_pause_len", 32'(n), 32'd32);
    chk("mflo_value", o_data_Lo, 32'd12);
    chk("mflo_hi", o_data_Hi, 32'd0);
    i_con_valid = 1'b0; i_con_mf = 2'b00;
    step();

    // MTLO issued while DIVU is in flight: held off, then applied after the result
    i_con_valid = 1'b1; i_con_op = 3'b100; i_data_A = 32'd7; i_data_B = 32'd2;
    step();
    i_con_op = 3'b110; i_data_A = 32'h0000_0055;
    #1;
    n = 0;
    while (o_con_pause && n < 100) begin
      n++;
      step();
    end
    chk("mtlo_pause_len", 32'(n), 32'd33);
    chk("mtlo_divlo", o_data_Lo, 32'd3);
    chk("mtlo_divhi", o_data_Hi, 32'd1);
    step();
    i_con_valid = 1'b0; i_con_op = 3'b000;
    chk("mtlo_lo", o_data_Lo, 32'h0000_0055);
    chk("mtlo_hi", o_data_Hi, 32'd1);

    // Asynchronous reset ten cycles into a MULT
    i_con_valid = 1'b1; i_con_op = 3'b001; i_data_A = 32'd9; i_data_B = 32'd9;
    step();
    i_con_valid = 1'b0; i_con_op = 3'b000;
    repeat (10) step();
    chk("pre_rst_busy", {31'd0, o_con_busy}, 32'd1);
    #2 i_rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, o_con_busy}, 32'd0);
    chk("arst_hi", o_data_Hi, 32'd0);
    chk("arst_lo", o_data_Lo, 32'd0);
    step(); step();
    i_rst = 1'b0;
    repeat (40) step();
    chk("post_rst_hi", o_data_Hi, 32'd0);
    chk("post_rst_lo", o_data_Lo, 32'd0);
    chk("post_rst_busy", {31'd0, o_con_busy}, 32'd0);

    do_op("mult2", 3'b001, 32'd6, 32'd7, 33);
    chk("mult2_lo", o_data_Lo, 32'd42);
    chk("mult2_hi", o_data_Hi, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
